// File: rtl/sap1_pkg.sv
// Shared types and constants for the SAP-1 controller-sequencer.
// Consumers may build with SAP1_VARIABLE_CYCLE_EN to enable early retire.
package sap1_pkg;

  localparam int NUM_T    = 6;
  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

  typedef enum logic [NUM_T-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_t;

  typedef struct packed {
    logic Cp;
    logic Ep;
    logic Lm;
    logic CE;
    logic Li;
    logic Ei;
    logic La;
    logic Ea;
    logic Su;
    logic Eu;
    logic Lb;
    logic Lo;
  } ctrl_word_t;

  // Active-low strobes idle high, active-high strobes idle low.
  localparam ctrl_word_t CW_IDLE = '{
    Cp: 1'b0, Ep: 1'b0, Lm: 1'b1, CE: 1'b1, Li: 1'b1, Ei: 1'b1,
    La: 1'b1, Ea: 1'b0, Su: 1'b0, Eu: 1'b0, Lb: 1'b1, Lo: 1'b1
  };

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring, clocked on the falling edge of CLK with async clear.
//   state | meaning
//   T1    | address state (PC -> MAR)
//   T2    | increment state (PC + 1)
//   T3    | memory state (RAM -> IR)
//   T4-T6 | execute states, opcode dependent
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic    CLK,
  input  logic    CLR_n,
  input  logic    hold_i,
  input  logic    wrap_i,
  output tstate_t tstate_o
);

  tstate_t ring_q, ring_d;

  always_ff @(negedge CLK or negedge CLR_n) begin
    if (!CLR_n) ring_q <= T1;
    else        ring_q <= ring_d;
  end

  always_comb begin
    ring_d = T1;
    if (hold_i) begin
      ring_d = ring_q;
    end else if (!wrap_i) begin
      case (ring_q)
        T1:      ring_d = T2;
        T2:      ring_d = T3;
        T3:      ring_d = T4;
        T4:      ring_d = T5;
        T5:      ring_d = T6;
        T6:      ring_d = T1;
        default: ring_d = T1;  // illegal encodings fall back to T1
      endcase
    end
  end

  assign tstate_o = ring_q;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: T-state ring plus opcode decode into the control word.
// Define SAP1_VARIABLE_CYCLE_EN to retire LDA after T5 and OUT after T4.
module sap1_controller_sequencer
  import sap1_pkg::*;
(
  input  logic                CLK,
  input  logic                CLR_n,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                Cp,
  output logic                Ep,
  output logic                Lm,
  output logic                CE,
  output logic                Li,
  output logic                Ei,
  output logic                La,
  output logic                Ea,
  output logic                Su,
  output logic                Eu,
  output logic                Lb,
  output logic                Lo,
  output logic                HLT,
  output logic [NUM_T-1:0]    tstate
);

  tstate_t    ring;
  logic       halt_q, halt_d;
  logic       wrap;
  ctrl_word_t cw;

  sap1_ring_counter u_ring (
    .CLK      (CLK),
    .CLR_n    (CLR_n),
    .hold_i   (halt_q),
    .wrap_i   (wrap),
    .tstate_o (ring)
  );

  // Halt latches on the same edge that moves the ring into T4.
  always_ff @(negedge CLK or negedge CLR_n) begin
    if (!CLR_n) halt_q <= 1'b0;
    else        halt_q <= halt_d;
  end

  always_comb begin
    halt_d = halt_q | ((ring == T3) && (opcode == OP_HLT));
  end

  always_comb begin
`ifdef SAP1_VARIABLE_CYCLE_EN
    wrap = ((ring == T5) && (opcode == OP_LDA)) ||
           ((ring == T4) && (opcode == OP_OUT));
`else
    wrap = 1'b0;
`endif
  end

  always_comb begin
    cw = CW_IDLE;
    if (!halt_q) begin
      case (ring)
        T1: begin cw.Ep = 1'b1; cw.Lm = 1'b0; end
        T2: begin cw.Cp = 1'b1; end
        T3: begin cw.CE = 1'b0; cw.Li = 1'b0; end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin cw.Lm = 1'b0; cw.Ei = 1'b0; end
            OP_OUT:                 begin cw.Ea = 1'b1; cw.Lo = 1'b0; end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA:         begin cw.CE = 1'b0; cw.La = 1'b0; end
            OP_ADD, OP_SUB: begin cw.CE = 1'b0; cw.Lb = 1'b0; end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin cw.La = 1'b0; cw.Eu = 1'b1; end
            OP_SUB: begin cw.La = 1'b0; cw.Eu = 1'b1; cw.Su = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo} = cw;
  assign HLT    = halt_q;
  assign tstate = ring;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Directed bench for the SAP-1 controller-sequencer; honours SAP1_VARIABLE_CYCLE_EN.
module tb_sap1_controller_sequencer;

  logic       CLK = 1'b0;
  logic       CLR_n = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, HLT;
  logic [5:0] tstate;
  logic [11:0] cw_obs;

  int checks = 0;
  int errors = 0;

  // Control word order {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
  localparam logic [11:0] CW_IDLE = 12'h3E3;
  localparam logic [11:0] CW_T1   = 12'h5E3;
  localparam logic [11:0] CW_T2   = 12'hBE3;
  localparam logic [11:0] CW_T3   = 12'h263;
  localparam logic [11:0] CW_MEI  = 12'h1A3;
  localparam logic [11:0] CW_LDA5 = 12'h2C3;
  localparam logic [11:0] CW_AB5  = 12'h2E1;
  localparam logic [11:0] CW_ADD6 = 12'h3C7;
  localparam logic [11:0] CW_SUB6 = 12'h3CF;
  localparam logic [11:0] CW_OUT4 = 12'h3F2;

`ifdef SAP1_VARIABLE_CYCLE_EN
  localparam int LDA_LEN = 5;
  localparam int OUT_LEN = 4;
`else
  localparam int LDA_LEN = 6;
  localparam int OUT_LEN = 6;
`endif

  sap1_controller_sequencer dut (
    .CLK(CLK), .CLR_n(CLR_n), .opcode(opcode),
    .Cp(Cp), .Ep(Ep), .Lm(Lm), .CE(CE), .Li(Li), .Ei(Ei), .La(La),
    .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo), .HLT(HLT), .tstate(tstate)
  );

  always #10 CLK = ~CLK;

  assign cw_obs = {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo};

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [5:0] ts, input logic [11:0] cw,
                              input logic hlt);
    @(posedge CLK); #1;
    check({tag, " tstate"}, 32'(tstate), 32'(ts));
    check({tag, " cw"},     32'(cw_obs), 32'(cw));
    check({tag, " HLT"},    32'(HLT),    32'(hlt));
  endtask

  // Called at a T1 sample point; checks T2..Tlen then the return to T1.
  task automatic run_instr(input string tag, input logic [3:0] op, input int len,
                           input logic [11:0] c4, input logic [11:0] c5, input logic [11:0] c6);
    logic [11:0] cws [1:6];
    cws[1] = CW_T1; cws[2] = CW_T2; cws[3] = CW_T3;
    cws[4] = c4;    cws[5] = c5;    cws[6] = c6;
    opcode = op;
    for (int k = 2; k <= len; k++)
      expect_state($sformatf("%s T%0d", tag, k), 6'b000001 << (k - 1), cws[k], 1'b0);
    expect_state({tag, " wrap T1"}, 6'b000001, CW_T1, 1'b0);
  endtask

  initial begin
    // Reset shows the T1 decode.
    #30;
    check("reset tstate", 32'(tstate), 32'h01);
    check("reset cw",     32'(cw_obs), 32'(CW_T1));
    check("reset HLT",    32'(HLT),    32'h0);
    #25 CLR_n = 1'b1;

    run_instr("LDA", 4'b0000, LDA_LEN, CW_MEI, CW_LDA5, CW_IDLE);
    run_instr("ADD", 4'b0001, 6, CW_MEI, CW_AB5, CW_ADD6);
    run_instr("SUB", 4'b0010, 6, CW_MEI, CW_AB5, CW_SUB6);
    run_instr("OUT", 4'b1110, OUT_LEN, CW_OUT4, CW_IDLE, CW_IDLE);
    run_instr("NOP", 4'b0111, 6, CW_IDLE, CW_IDLE, CW_IDLE);

    // Reset in the middle of LDA T5: immediate return to T1, no La afterwards.
    opcode = 4'b0000;
    expect_state("rstmid T2", 6'b000010, CW_T2, 1'b0);
    expect_state("rstmid T3", 6'b000100, CW_T3, 1'b0);
    expect_state("rstmid T4", 6'b001000, CW_MEI, 1'b0);
    @(negedge CLK); #2;
    CLR_n = 1'b0;
    #1;
    check("rstmid async tstate", 32'(tstate), 32'h01);
    check("rstmid async La",     32'(La),     32'h1);
    check("rstmid async cw",     32'(cw_obs), 32'(CW_T1));
    expect_state("rstmid held", 6'b000001, CW_T1, 1'b0);
    #5 CLR_n = 1'b1;
    expect_state("rstmid rel T2", 6'b000010, CW_T2, 1'b0);
    expect_state("rstmid rel T3", 6'b000100, CW_T3, 1'b0);
    expect_state("rstmid rel T4", 6'b001000, CW_MEI, 1'b0);
    expect_state("rstmid rel T5", 6'b010000, CW_LDA5, 1'b0);
    if (LDA_LEN == 6) expect_state("rstmid rel T6", 6'b100000, CW_IDLE, 1'b0);
    expect_state("rstmid rel T1", 6'b000001, CW_T1, 1'b0);

    // HLT freezes at T4 with an idle control word until CLR_n.
    opcode = 4'b1111;
    expect_state("HLT T2", 6'b000010, CW_T2, 1'b0);
    expect_state("HLT T3", 6'b000100, CW_T3, 1'b0);
    expect_state("HLT T4", 6'b001000, CW_IDLE, 1'b1);
    for (int i = 0; i < 20; i++)
      expect_state($sformatf("HLT hold %0d", i), 6'b001000, CW_IDLE, 1'b1);
    CLR_n = 1'b0;
    #1;
    check("HLT clr tstate", 32'(tstate), 32'h01);
    check("HLT clr HLT",    32'(HLT),    32'h0);
    check("HLT clr cw",     32'(cw_obs), 32'(CW_T1));
    opcode = 4'b0001;
    #4 CLR_n = 1'b1;
    run_instr("post-HLT ADD", 4'b0001, 6, CW_MEI, CW_AB5, CW_ADD6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
